lsu_issue_queue: RTL and testbench
==================================

Name: lsu_issue_queue

Overview:
- In-order memory request queue sitting directly upstream of the 16-bit load/store unit.
- Accepts memory ops from the reservation stations and computes the effective address (base + offset, mod 2^16).
- Steers byte-write data onto both bus lanes and buffers up to DEPTH requests.
- Presents the oldest request to the LSU using its rq_start / rq_hold handshake.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- a_rst  in  1  asynchronous active-low reset.
- in_valid  in  1  reservation station presents a memory op.
- in_base  in  16  address base operand.
- in_offset  in  16  address offset operand.
- in_data  in  16  store data; ignored for reads.
- in_width  in  1  0: 16-bit, 1: 8-bit.
- in_cmd  in  1  0: read, 1: write.
- in_tag  in  2  reservation-station tag.
- in_ready  out  1  queue can accept this cycle.
- flush  in  1  discard all queued (not yet issued) entries.
- rq_addr  out  16  head entry effective address.
- rq_data  out  16  head entry lane-steered data.
- rq_width  out  1  head entry width.
- rq_cmd  out  1  head entry command.
- rq_tag  out  2  head entry tag.
- rq_start  out  1  head entry valid; request to the LSU.
- rq_hold  in  1  LSU cannot accept this cycle.
- misalign  out  1  one-cycle pulse: an issued entry was 16-bit at an odd address.
- q_count  out  PTR_W+1  current occupancy.

Behaviour:
- Reset (async, a_rst low): rd_ptr = 0, wr_ptr = 0, count = 0, misalign = 0. Therefore rq_start = 0, in_ready = 1, q_count = 0. Entry storage is not reset; rq_addr/rq_data/rq_width/rq_cmd/rq_tag are don't-care while rq_start = 0.
- Push:
  - push = in_valid & in_ready.
  - in_ready = (count != DEPTH) & ~flush. There is no pass-through when full, even if a pop occurs in the same cycle.
  - On push, the entry written at wr_ptr holds:
    - addr = in_base + in_offset, truncated to 16 bits (wraps: 0xFFFF + 0x0002 = 0x0001).
    - data = in_data if in_width = 0; {in_data[7:0], in_data[7:0]} if in_width = 1.
    - width, cmd, tag copied from the inputs.
  - wr_ptr increments, wrapping modulo DEPTH.
- Issue:
  - rq_start = (count != 0). rq_* outputs are driven combinationally from the entry at rd_ptr; there are no combinational paths from in_* to rq_*.
  - pop = rq_start & ~rq_hold, the same condition under which the LSU latches the request.
  - On pop, rd_ptr increments (wrapping).
  - rq_start stays asserted, with stable rq_* outputs, for as long as rq_hold is high.
- Latency: a push into an empty queue appears on rq_start on the next cycle. Minimum queue-to-LSU latency is 1 cycle; no same-cycle bypass.
- Throughput: 1 issue per cycle while rq_hold = 0.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- Flush:
  - A pop in the flush cycle still completes, because the LSU has latched that request.
  - All other entries are discarded at the edge: count = 0, rd_ptr = wr_ptr.
  - A push is blocked in the flush cycle (in_ready = 0).
  - rq_start is not gated by flush in the flush cycle.
- misalign: registered. It equals 1 on the cycle after a pop of an entry with width = 0 and addr[0] = 1; otherwise 0. The entry is still forwarded unchanged.
- q_count = count, which ranges 0..DEPTH.

Decomposition:
- Shared header lsu_defs, used with the LSU:
  - LSU_W16 = 0, LSU_W8 = 1, LSU_RD = 0, LSU_WR = 1.
  - Entry field widths: ADDR 16, DATA 16, TAG 2.
- Sub-module lsu_agu: purely combinational 16-bit adder plus byte-lane replication. It produces the entry fields from in_base, in_offset, in_data and in_width. It is reused by any future second issue port.

Test Plan:
- Reset, then push base 0x1000, offset 0x0004, 16-bit write, data 0xBEEF, tag 2, rq_hold = 0 -> next cycle rq_start = 1, rq_addr = 0x1004, rq_data = 0xBEEF, rq_tag = 2; the following cycle rq_start = 0.
- Push an 8-bit write with data 0x12AB at base 0xFFFF, offset 0x0002 -> rq_addr = 0x0001, rq_data = 0xABAB, rq_width = 1; misalign = 0.
- Hold rq_hold = 1 and push 5 ops -> in_ready = 0 after the 4th push, q_count = 4, rq_* frozen on op 1. Release rq_hold -> ops 1..4 issue on consecutive cycles in order; in_ready returns to 1 on the cycle after the first pop.
- Queue holding 3 entries, rq_hold = 0, flush = 1 for one cycle with in_valid = 1 -> head entry issues, new op not accepted; next cycle q_count = 0, rq_start = 0.
- 16-bit read at addr 0x2003 issued -> misalign = 1 for exactly one cycle after the pop; the request is forwarded unchanged.
- Assert a_rst low mid-operation with 2 entries queued and rq_hold = 1 -> rq_start = 0 and q_count = 0 immediately (asynchronous), in_ready = 1.

Source files
------------

// File: rtl/lsu_issue_queue_pkg.sv
// Shared LSU definitions: encodings, entry field widths and the queue entry layout.
// Also holds the byte-lane steering helper used by the address generation unit.
package lsu_issue_queue_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 2;

  localparam logic LSU_W16 = 1'b0;
  localparam logic LSU_W8  = 1'b1;
  localparam logic LSU_RD  = 1'b0;
  localparam logic LSU_WR  = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              width;
    logic              cmd;
    logic [TAG_W-1:0]  tag;
  } lsu_entry_t;

  // Byte ops place the low byte on both lanes so the LSU can pick either one.
  function automatic logic [DATA_W-1:0] lane_steer(input logic [DATA_W-1:0] d,
                                                   input logic              w);
    if (w == LSU_W8) begin
      return {d[7:0], d[7:0]};
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/lsu_issue_queue_agu.sv
// Address generation unit: effective address (base + offset, wrapping at 16 bits)
// and byte-lane replication of store data. Purely combinational.
module lsu_agu
  import lsu_issue_queue_pkg::*;
(
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] offset_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              width_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  assign addr_o = base_i + offset_i;
  assign data_o = lane_steer(data_i, width_i);

endmodule

// File: rtl/lsu_issue_queue.sv
// In-order memory request queue in front of the 16-bit LSU. Buffers up to DEPTH
// requests and presents the oldest one using the rq_start / rq_hold handshake.
module lsu_issue_queue
  import lsu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] in_offset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_width,
  input  logic              in_cmd,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              in_ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] rq_addr,
  output logic [DATA_W-1:0] rq_data,
  output logic              rq_width,
  output logic              rq_cmd,
  output logic [TAG_W-1:0]  rq_tag,
  output logic              rq_start,
  input  logic              rq_hold,
  output logic              misalign,
  output logic [PTR_W:0]    q_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             misalign_q, misalign_d;
  lsu_entry_t       mem_q [DEPTH];

  logic             push_s, pop_s;
  lsu_entry_t       new_entry_s, head_s;
  logic [ADDR_W-1:0] agu_addr_s;
  logic [DATA_W-1:0] agu_data_s;

  lsu_agu u_agu (
    .base_i   (in_base),
    .offset_i (in_offset),
    .data_i   (in_data),
    .width_i  (in_width),
    .addr_o   (agu_addr_s),
    .data_o   (agu_data_s)
  );

  assign new_entry_s = '{addr: agu_addr_s, data: agu_data_s, width: in_width,
                         cmd: in_cmd, tag: in_tag};
  assign head_s      = mem_q[rd_ptr_q];

  // No pass-through when full: a same-cycle pop does not free a slot for the push.
  assign in_ready = (count_q != FULL_CNT) & ~flush;
  assign rq_start = (count_q != '0);
  assign push_s   = in_valid & in_ready;
  assign pop_s    = rq_start & ~rq_hold;

  assign rq_addr  = head_s.addr;
  assign rq_data  = head_s.data;
  assign rq_width = head_s.width;
  assign rq_cmd   = head_s.cmd;
  assign rq_tag   = head_s.tag;
  assign misalign = misalign_q;
  assign q_count  = count_q;

  // Next-state: flush drops everything not already latched by the LSU.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    misalign_d = pop_s & (head_s.width == LSU_W16) & head_s.addr[0];
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= new_entry_s;
    end
  end

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Self-checking bench for lsu_issue_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_lsu_issue_queue;

  typedef struct {
    int unsigned addr;
    int unsigned data;
    int unsigned width;
    int unsigned cmd;
    int unsigned tag;
  } op_t;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        in_valid;
  logic [15:0] in_base, in_offset, in_data;
  logic        in_width, in_cmd;
  logic [1:0]  in_tag;
  logic        in_ready;
  logic        flush;
  logic [15:0] rq_addr, rq_data;
  logic        rq_width, rq_cmd;
  logic [1:0]  rq_tag;
  logic        rq_start;
  logic        rq_hold;
  logic        misalign;
  logic [2:0]  q_count;

  int vectors = 0;
  int miscompares = 0;

  op_t model_q[$];
  int  model_mis = 0;

  lsu_issue_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .a_rst(a_rst), .in_valid(in_valid), .in_base(in_base),
    .in_offset(in_offset), .in_data(in_data), .in_width(in_width),
    .in_cmd(in_cmd), .in_tag(in_tag), .in_ready(in_ready), .flush(flush),
    .rq_addr(rq_addr), .rq_data(rq_data), .rq_width(rq_width), .rq_cmd(rq_cmd),
    .rq_tag(rq_tag), .rq_start(rq_start), .rq_hold(rq_hold),
    .misalign(misalign), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [15:0] b, input logic [15:0] o,
                       input logic [15:0] d, input logic w, input logic c,
                       input logic [1:0] t, input logic h, input logic f);
    in_valid = v; in_base = b; in_offset = o; in_data = d;
    in_width = w; in_cmd = c; in_tag = t; rq_hold = h; flush = f;
    #1;
  endtask

  // Advance the reference model by one clock using the currently driven inputs.
  task automatic tick();
    bit  do_push, do_pop;
    op_t n, h;
    do_push = in_valid && (model_q.size() != 4) && !flush;
    do_pop  = (model_q.size() != 0) && !rq_hold;
    model_mis = 0;
    if (do_pop) begin
      h = model_q.pop_front();
      model_mis = (h.width == 0 && (h.addr % 2) == 1) ? 1 : 0;
    end
    if (flush) model_q.delete();
    if (do_push) begin
      n.addr  = (int'(in_base) + int'(in_offset)) % 65536;
      n.data  = in_width ? (int'(in_data) % 256) * 257 : int'(in_data);
      n.width = in_width; n.cmd = in_cmd; n.tag = in_tag;
      model_q.push_back(n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic h);
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 2'd0, h, 1'b0);
  endtask

  task automatic test_reset();
    a_rst = 1'b0;
    idle(1'b0);
    model_q.delete(); model_mis = 0;
    vectors++; if (rq_start !== 1'b0) begin miscompares++; $display("FAIL reset_start got %0b want 0", rq_start); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %0b want 1", in_ready); end
    vectors++; if (q_count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", q_count); end
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL reset_misalign got %0b want 0", misalign); end
    @(posedge clk); #1;
    a_rst = 1'b1;
  endtask

  task automatic test_basic();
    drive(1'b1, 16'h1000, 16'h0004, 16'hBEEF, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    vectors++; if (rq_start !== 1'b1) begin miscompares++; $display("FAIL basic_start got %0b want 1", rq_start); end
    vectors++; if (rq_addr !== 16'h1004) begin miscompares++; $display("FAIL basic_addr got %h want 1004", rq_addr); end
    vectors++; if (rq_data !== 16'hBEEF) begin miscompares++; $display("FAIL basic_data got %h want beef", rq_data); end
    vectors++; if (rq_tag !== 2'd2) begin miscompares++; $display("FAIL basic_tag got %0d want 2", rq_tag); end
    vectors++; if ({rq_width, rq_cmd} !== 2'b01) begin miscompares++; $display("FAIL basic_wc got %b want 01", {rq_width, rq_cmd}); end
    tick();
    vectors++; if (rq_start !== 1'b0) begin miscompares++; $display("FAIL basic_drain got %0b want 0", rq_start); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 16'hFFFF, 16'h0002, 16'h12AB, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    vectors++; if (rq_addr !== 16'h0001) begin miscompares++; $display("FAIL wrap_addr got %h want 0001", rq_addr); end
    vectors++; if (rq_data !== 16'hABAB) begin miscompares++; $display("FAIL wrap_data got %h want abab", rq_data); end
    vectors++; if (rq_width !== 1'b1) begin miscompares++; $display("FAIL wrap_width got %0b want 1", rq_width); end
    tick();
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL wrap_misalign got %0b want 0", misalign); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h3000 + 16'(i * 16), 16'h0000, 16'(i), 1'b0, 1'b0, 2'(i), 1'b1, 1'b0);
      vectors++; if (in_ready !== (i < 4)) begin miscompares++; $display("FAIL full_ready%0d got %0b want %0b", i, in_ready, i < 4); end
      if (i > 0) begin
        vectors++; if (rq_addr !== 16'h3000) begin miscompares++; $display("FAIL full_frozen%0d got %h want 3000", i, rq_addr); end
      end
      tick();
    end
    idle(1'b1);
    vectors++; if (q_count !== 3'd4) begin miscompares++; $display("FAIL full_count got %0d want 4", q_count); end
    idle(1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (rq_start !== 1'b1) begin miscompares++; $display("FAIL full_issue_start%0d got %0b want 1", i, rq_start); end
      vectors++; if (rq_addr !== 16'h3000 + 16'(i * 16)) begin miscompares++; $display("FAIL full_issue_addr%0d got %h want %h", i, rq_addr, 16'h3000 + 16'(i * 16)); end
      vectors++; if (in_ready !== (i > 0)) begin miscompares++; $display("FAIL full_issue_ready%0d got %0b want %0b", i, in_ready, i > 0); end
      tick();
    end
    vectors++; if (rq_start !== 1'b0) begin miscompares++; $display("FAIL full_empty got %0b want 0", rq_start); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h4000, 16'(i * 2), 16'h5555, 1'b0, 1'b1, 2'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 16'h7000, 16'h0000, 16'h1111, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
    vectors++; if (rq_start !== 1'b1) begin miscompares++; $display("FAIL flush_start got %0b want 1", rq_start); end
    vectors++; if (rq_addr !== 16'h4000) begin miscompares++; $display("FAIL flush_head got %h want 4000", rq_addr); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready got %0b want 0", in_ready); end
    tick();
    idle(1'b0);
    vectors++; if (q_count !== 3'd0) begin miscompares++; $display("FAIL flush_count got %0d want 0", q_count); end
    vectors++; if (rq_start !== 1'b0) begin miscompares++; $display("FAIL flush_after got %0b want 0", rq_start); end
    tick();
  endtask

  task automatic test_misalign();
    drive(1'b1, 16'h2000, 16'h0003, 16'h9999, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    vectors++; if (rq_addr !== 16'h2003 || rq_cmd !== 1'b0 || rq_width !== 1'b0) begin miscompares++; $display("FAIL mis_fwd got %h/%0b/%0b want 2003/0/0", rq_addr, rq_cmd, rq_width); end
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL mis_early got %0b want 0", misalign); end
    tick();
    vectors++; if (misalign !== 1'b1) begin miscompares++; $display("FAIL mis_pulse got %0b want 1", misalign); end
    tick();
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL mis_clear got %0b want 0", misalign); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h6000, 16'(i), 16'h0, 1'b0, 1'b0, 2'(i), 1'b1, 1'b0);
      tick();
    end
    idle(1'b1);
    vectors++; if (q_count !== 3'd2) begin miscompares++; $display("FAIL areset_pre got %0d want 2", q_count); end
    a_rst = 1'b0;
    #1;
    model_q.delete(); model_mis = 0;
    vectors++; if (rq_start !== 1'b0) begin miscompares++; $display("FAIL areset_start got %0b want 0", rq_start); end
    vectors++; if (q_count !== 3'd0) begin miscompares++; $display("FAIL areset_count got %0d want 0", q_count); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL areset_ready got %0b want 1", in_ready); end
    #1;
    a_rst = 1'b1;
    idle(1'b0);
    tick();
  endtask

  task automatic test_random();
    logic [15:0] b;
    for (int n = 0; n < 400; n++) begin
      b = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      drive($urandom_range(0, 9) < 7, b, 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom),
            $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
      vectors++; if (rq_start !== (model_q.size() != 0)) begin miscompares++; $display("FAIL rnd_start@%0d got %0b want %0b", n, rq_start, model_q.size() != 0); end
      vectors++; if (in_ready !== (model_q.size() != 4 && !flush)) begin miscompares++; $display("FAIL rnd_ready@%0d got %0b", n, in_ready); end
      vectors++; if (int'(q_count) != model_q.size()) begin miscompares++; $display("FAIL rnd_count@%0d got %0d want %0d", n, q_count, model_q.size()); end
      vectors++; if (int'(misalign) != model_mis) begin miscompares++; $display("FAIL rnd_misalign@%0d got %0b want %0d", n, misalign, model_mis); end
      if (model_q.size() != 0) begin
        vectors++;
        if (int'(rq_addr) != model_q[0].addr || int'(rq_data) != model_q[0].data ||
            int'(rq_width) != model_q[0].width || int'(rq_cmd) != model_q[0].cmd ||
            int'(rq_tag) != model_q[0].tag) begin
          miscompares++;
          $display("FAIL rnd_head@%0d got %h/%h/%0b/%0b/%0d want %h/%h/%0d/%0d/%0d", n,
                   rq_addr, rq_data, rq_width, rq_cmd, rq_tag, model_q[0].addr,
                   model_q[0].data, model_q[0].width, model_q[0].cmd, model_q[0].tag);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_flush();
    test_misalign();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
